// File: rtl/tile_map_arbiter.sv
// Generic FIFO: count-based full/empty, pointers wrap modulo DEPTH.
// Latency: a pushed entry is at the head the cycle after the push.
// Backpressure: none internal; the caller must gate push on count < DEPTH.
module tile_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

// Tile-map RAM arbiter: graphics reads win outright, game writes drain in blanking.
// Latency: read data 2 cycles after gfx_req; queued writes commit 1 cycle after a drain slot.
// Backpressure: wr_ready drops when the write queue is full; graphics reads are never stalled.
module tile_map_arbiter #(
    parameter int MAP_ENTRIES = 300,
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clock_50,
    input  logic              reset_key,
    input  logic              video_on,
    input  logic              gfx_req,
    input  logic [ADDR_W-1:0] gfx_addr,
    output logic              gfx_valid,
    output logic [DATA_W-1:0] gfx_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [CNT_W-1:0]  wr_pending,
    output logic              err_oob,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    typedef enum logic [1:0] {ST_IDLE, ST_GFX, ST_DRAIN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_ent_t;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]  MAP_LIMIT = (ADDR_W + 1)'(MAP_ENTRIES);

    state_t  state;
    state_t  next_state;
    wr_ent_t head;
    wr_ent_t wr_ent;
    logic    wr_acc;
    logic    in_range;
    logic    push;
    logic    pop;

    assign wr_ready = (wr_pending < FULL_CNT);
    assign wr_acc   = wr_req && wr_ready;
    assign in_range = ({1'b0, wr_addr} < MAP_LIMIT);
    assign push     = wr_acc && in_range;
    assign wr_ent   = '{addr: wr_addr, data: wr_data};

    tile_fifo #(
        .WIDTH ($bits(wr_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk      (clock_50),
        .rst      (reset_key),
        .push     (push),
        .push_dat (wr_ent),
        .pop      (pop),
        .head_dat (head),
        .count    (wr_pending)
    );

    always_comb begin
        next_state = ST_IDLE;
        if (gfx_req)
            next_state = ST_GFX;
        else if (!video_on && (wr_pending != '0))
            next_state = ST_DRAIN;
    end

    assign pop = (next_state == ST_DRAIN);

    always_ff @(posedge clock_50 or posedge reset_key) begin
        if (reset_key) state <= ST_IDLE;
        else           state <= next_state;
    end

    always_ff @(posedge clock_50 or posedge reset_key) begin
        if (reset_key) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else begin
            case (next_state)
                ST_GFX: begin
                    ram_addr <= gfx_addr;
                    ram_we   <= 1'b0;
                end
                ST_DRAIN: begin
                    ram_addr  <= head.addr;
                    ram_wdata <= head.data;
                    ram_we    <= 1'b1;
                end
                default: ram_we <= 1'b0;
            endcase
        end
    end

    // A GFX state means the RAM is reading that address now, so its data lands next cycle.
    always_ff @(posedge clock_50 or posedge reset_key) begin
        if (reset_key) begin
            gfx_valid <= 1'b0;
            err_oob   <= 1'b0;
        end else begin
            gfx_valid <= (state == ST_GFX);
            if (wr_acc && !in_range) err_oob <= 1'b1;
        end
    end

    assign gfx_data = gfx_valid ? ram_rdata : '0;
endmodule
